// File: rtl/button_repeat_if.sv
// Button repeat bus: enable, timebase strobe, button level in; strobes and held level out.
// master drives the inputs (controller/bench); slave is the button_repeat block.
interface button_repeat_if;
    logic i_en;
    logic i_tick_stb;
    logic i_button_state;
    logic o_press_stb;
    logic o_repeat_stb;
    logic o_event_stb;
    logic o_release_stb;
    logic o_held;

    modport master (
        output i_en, i_tick_stb, i_button_state,
        input  o_press_stb, o_repeat_stb, o_event_stb,
        input  o_release_stb, o_held
    );

    modport slave (
        input  i_en, i_tick_stb, i_button_state,
        output o_press_stb, o_repeat_stb, o_event_stb,
        output o_release_stb, o_held
    );
endinterface

// File: rtl/button_repeat.sv
// Button press / auto-repeat / release strobe generator on a tick timebase.
// Ports: i_clk, i_reset (sync, active-high), bus (button_repeat_if.slave).
// Macro BUTTON_REPEAT_AUTOREPEAT_EN enables the REPEAT state; without it a
// held button yields only press and release strobes.
module button_repeat #(
    parameter int HOLD_TICKS   = 8,
    parameter int REPEAT_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    button_repeat_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
`ifdef BUTTON_REPEAT_AUTOREPEAT_EN
    localparam logic [1:0] S_REPEAT  = 2'd2;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             repeat_q, repeat_d;
    logic             release_q, release_d;
    logic             event_q, event_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        press_d   = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;
        if (bus.i_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_button_state) begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                S_PRESSED: begin
                    // release wins over a coincident tick
                    if (!bus.i_button_state) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                    end
`ifdef BUTTON_REPEAT_AUTOREPEAT_EN
                    else if (bus.i_tick_stb) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d  = S_REPEAT;
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                            held_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
`endif
                end
`ifdef BUTTON_REPEAT_AUTOREPEAT_EN
                S_REPEAT: begin
                    if (!bus.i_button_state) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                    end else if (bus.i_tick_stb) begin
                        if (cnt_q == REP_LAST) begin
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end
            endcase
        end
        event_d = press_d | repeat_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
            event_q   <= event_d;
            held_q    <= held_d;
        end
    end

`ifndef BUTTON_REPEAT_AUTOREPEAT_EN
    // PRESSED is terminal: tick input, counter and timing knobs go unused
    logic unused_cfg;
    assign unused_cfg = ^{bus.i_tick_stb, cnt_q,
                          HOLD_TICKS[0], REPEAT_TICKS[0]};
`endif

    assign bus.o_press_stb   = press_q;
    assign bus.o_repeat_stb  = repeat_q;
    assign bus.o_release_stb = release_q;
    assign bus.o_event_stb   = event_q;
    assign bus.o_held        = held_q;

endmodule

// File: tb/tb_button_repeat.sv
// Self-checking bench for button_repeat against a tick-counting reference model.
// Directed scenarios on a 10-clock tick, then randomized traffic.
module tb_button_repeat;

    localparam int HOLD = 4;
    localparam int REP  = 2;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // reference model state
    bit m_active = 0;
    int m_ticks = 0;
    bit m_held = 0;
    bit m_press = 0, m_rep = 0, m_rel = 0;
    int m_rep_cnt = 0;

    // observed strobe counts
    int n_press = 0, n_rep = 0, n_rel = 0;

    button_repeat_if bus ();

    button_repeat #(
        .HOLD_TICKS(HOLD),
        .REPEAT_TICKS(REP),
        .CNT_W(8)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en,
                        input logic btn, input logic tick);
        int nstb;
        rst = r;
        bus.i_en = en;
        bus.i_button_state = btn;
        bus.i_tick_stb = tick;
        @(posedge clk);
        cyc++;
        m_press = 0;
        m_rep = 0;
        m_rel = 0;
        if (r) begin
            m_active = 0;
            m_ticks = 0;
            m_held = 0;
        end else if (en) begin
            if (!m_active) begin
                if (btn) begin
                    m_active = 1;
                    m_ticks = 0;
                    m_press = 1;
                end
            end else if (!btn) begin
                m_active = 0;
                m_held = 0;
                m_rel = 1;
            end else if (tick) begin
                m_ticks++;
`ifdef BUTTON_REPEAT_AUTOREPEAT_EN
                // repeats fall on ticks HOLD, HOLD+REP, HOLD+2*REP, ...
                if (m_ticks >= HOLD && (m_ticks - HOLD) % REP == 0) begin
                    m_rep = 1;
                    m_held = 1;
                end
`endif
            end
        end
        if (m_rep) m_rep_cnt++;
        #1;
        chk("press", bus.o_press_stb, m_press);
        chk("repeat", bus.o_repeat_stb, m_rep);
        chk("release", bus.o_release_stb, m_rel);
        chk("event", bus.o_event_stb, m_press | m_rep);
        chk("held", bus.o_held, m_held);
        nstb = int'(bus.o_press_stb) + int'(bus.o_repeat_stb)
             + int'(bus.o_release_stb);
        chk("onehot", nstb <= 1, 1'b1);
        n_press += int'(bus.o_press_stb);
        n_rep += int'(bus.o_repeat_stb);
        n_rel += int'(bus.o_release_stb);
    endtask

    // tick every 10 clocks
    task automatic run(input int n, input logic btn, input logic en);
        for (int i = 0; i < n; i++)
            step(1'b0, en, btn, (cyc % 10) == 9);
    endtask

    task automatic clr_cnt();
        n_press = 0;
        n_rep = 0;
        n_rel = 0;
        m_rep_cnt = 0;
    endtask

    initial begin
        int g;
        logic btn;
        // reset
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);

        // short press: press and release only
        clr_cnt();
        run(15, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        chk_int("short_press_n", n_press, 1);
        chk_int("short_rel_n", n_rel, 1);
        chk_int("short_rep_n", n_rep, 0);

        // long hold
        clr_cnt();
        run(100, 1'b1, 1'b1);
        chk_int("hold_press_n", n_press, 1);
        chk_int("hold_rep_n", n_rep, m_rep_cnt);
`ifdef BUTTON_REPEAT_AUTOREPEAT_EN
        chk("hold_rep_some", n_rep >= 3, 1'b1);
`else
        chk_int("hold_rep_none", n_rep, 0);
`endif
        run(5, 1'b0, 1'b1);

        // release on the 6th tick
        run(1, 1'b1, 1'b1);
        g = 0;
        while (m_ticks < 5 && g < 200) begin
            run(1, 1'b1, 1'b1);
            g++;
        end
        while ((cyc % 10) != 9 && g < 200) begin
            run(1, 1'b1, 1'b1);
            g++;
        end
        chk("tick6_bound", g < 200, 1'b1);
        run(1, 1'b0, 1'b1);
        chk("tick6_rel", bus.o_release_stb, 1'b1);
        chk("tick6_norep", bus.o_repeat_stb, 1'b0);
        run(1, 1'b0, 1'b1);
        chk("tick6_held", bus.o_held, 1'b0);
        run(5, 1'b0, 1'b1);

        // disable with two ticks counted
        run(1, 1'b1, 1'b1);
        g = 0;
        while (m_ticks < 2 && g < 100) begin
            run(1, 1'b1, 1'b1);
            g++;
        end
        chk("en_bound", g < 100, 1'b1);
        clr_cnt();
        run(30, 1'b1, 1'b0);
        chk_int("dis_strobes", n_press + n_rep + n_rel, 0);
        clr_cnt();
        run(40, 1'b1, 1'b1);
        chk_int("reen_rep_n", n_rep, m_rep_cnt);

        // reset mid-hold with button still high
        clr_cnt();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_held", bus.o_held, 1'b0);
        run(1, 1'b1, 1'b1);
        chk("rst_repress", bus.o_press_stb, 1'b1);
        chk_int("rst_no_rel", n_rel, 0);
        run(5, 1'b0, 1'b1);

        // randomized traffic
        btn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) != 0,
                 btn,
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_repeat.md
BUTTON_REPEAT -- requirements
Module: button_repeat

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 8: i_tick_stb strobes from press to first auto-repeat pulse.
REQ-002 SHALL have parameter REPEAT_TICKS, default 2: i_tick_stb strobes between successive auto-repeat pulses.
REQ-003 SHALL have parameter CNT_W, default 8: tick counter width; HOLD_TICKS and REPEAT_TICKS each SHALL be in 1..2^CNT_W-1.
REQ-004 SHALL have port i_clk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port i_en, input, 1: global enable.
REQ-007 SHALL have port i_tick_stb, input, 1: one-cycle timebase strobe, e.g. 100 Hz.
REQ-008 SHALL have port i_button_state, input, 1: debounced button level, 1 = pressed, already synchronous to i_clk.
REQ-009 SHALL have port o_press_stb, output, 1: one-cycle pulse on accepted press.
REQ-010 SHALL have port o_repeat_stb, output, 1: one-cycle pulse per auto-repeat.
REQ-011 SHALL have port o_event_stb, output, 1: o_press_stb OR o_repeat_stb, for increment logic.
REQ-012 SHALL have port o_release_stb, output, 1: one-cycle pulse on release.
REQ-013 SHALL have port o_held, output, 1: level, high while in REPEAT.

Function
REQ-014 SHALL implement states IDLE, PRESSED and REPEAT, plus tick counter cnt of CNT_W bits; all outputs registered.
REQ-015 SHALL, when i_en=0, hold state and cnt unchanged and drive all strobes low on the next edge; o_held SHALL keep its value.
REQ-016 SHALL, in IDLE with i_en=1 and i_button_state=1: go to PRESSED, set cnt=0, and set o_press_stb=1 on that edge (1-cycle latency from input rise).
REQ-017 SHALL, in PRESSED with i_tick_stb=1: if cnt==HOLD_TICKS-1, go to REPEAT, set cnt=0, pulse o_repeat_stb and set o_held=1; otherwise increment cnt.
REQ-018 SHALL, in REPEAT with i_tick_stb=1: if cnt==REPEAT_TICKS-1, pulse o_repeat_stb and set cnt=0; otherwise increment cnt.
REQ-019 SHALL, in PRESSED or REPEAT with i_en=1 and i_button_state=0: go to IDLE, clear cnt and o_held, and pulse o_release_stb; release SHALL take priority over a coincident i_tick_stb (no repeat pulse that cycle).
REQ-020 SHALL not count i_tick_stb in the press-accept cycle (IDLE to PRESSED).
REQ-021 SHALL assert at most one of o_press_stb, o_repeat_stb, o_release_stb in any cycle.
REQ-022 SHALL, if the button goes high while i_en=0, produce the press on the first enabled cycle (level-based detection).
REQ-023 SHALL never wrap cnt; by construction it is cleared at its terminal value.

Reset
REQ-024 SHALL, with i_reset=1 at a rising edge, set state=IDLE, cnt=0, and every output 0; reset SHALL take priority over i_en.
REQ-025 SHALL, if reset is asserted mid-hold, generate no o_release_stb, and SHALL produce a fresh o_press_stb if the button is still high after reset deasserts.

Configuration
REQ-026 SHALL honour macro BUTTON_REPEAT_AUTOREPEAT_EN; when defined, behaviour is as in REQ-017/018.
REQ-027 SHALL, when BUTTON_REPEAT_AUTOREPEAT_EN is undefined: make PRESSED terminal until release, omit REPEAT and its logic, tie o_repeat_stb and o_held to 0, and make o_event_stb equal o_press_stb; press and release behaviour SHALL be unchanged.

Verification (HOLD_TICKS=4, REPEAT_TICKS=2, tick every 10 clocks, macro defined unless noted)
REQ-028 Bench: button high for 15 clocks then low -> exactly one o_press_stb, one cycle after the rise, then one o_release_stb, one cycle after the fall; no o_repeat_stb.
REQ-029 Bench: button held for 100 clocks -> o_repeat_stb on the 4th tick after press, then on every 2nd tick (ticks 4, 6, 8); o_held high from the first repeat until release.
REQ-030 Bench: release coincident with the 6th tick -> o_release_stb only, no repeat pulse; state IDLE, o_held=0 next cycle.
REQ-031 Bench: i_en=0 for 30 clocks during PRESSED with cnt=2 -> cnt frozen at 2, no strobes; after re-enable the first repeat occurs 2 ticks later.
REQ-032 Bench: i_reset=1 for 1 cycle while in REPEAT with button still high -> all outputs 0, no release pulse, o_press_stb on the next cycle.
REQ-033 Bench: macro undefined, button held for 100 clocks -> a single o_press_stb, o_repeat_stb and o_held constant 0, o_event_stb identical to o_press_stb.
